// File: rtl/sal_rd_ctrl.sv
// Read-data return path: tracks outstanding RD commands, tags DFI read beats
// with AXI ID/last and buffers them for the AXI R channel. Macro: SAL_RD_PARITY_CHK_EN.
module sal_rd_ctrl #(
  parameter int DATA_W     = 64,
  parameter int ID_W       = 4,
  parameter int BEATS      = 2,
  parameter int TAG_DEPTH  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_gnt,
  input  logic [ID_W-1:0]   rd_id,
  input  logic              rd_last,
  output logic              rd_ready,
  input  logic              dfi_rddata_valid,
  input  logic [DATA_W-1:0] dfi_rddata,
  input  logic              dfi_rddata_par,
  output logic              rvalid,
  input  logic              rready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              err_unexp
);

  localparam int TAG_AW  = $clog2(TAG_DEPTH);
  localparam int TAG_PW  = TAG_AW + 1;
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int FIFO_PW = FIFO_AW + 1;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            last;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic              last;
    logic [1:0]        resp;
  } beat_t;

  tag_t              tag_mem [TAG_DEPTH];
  logic [TAG_PW-1:0] tag_wp, tag_rp, tag_cnt, tag_cnt_nxt;
  logic              tag_full, tag_empty, tag_push, tag_pop;
  tag_t              tag_head;

  beat_t              dmem [FIFO_DEPTH];
  logic [FIFO_PW-1:0] d_wp, d_rp, d_cnt, d_cnt_nxt;
  logic               d_full, d_empty, d_push, out_load;
  beat_t              r_q, beat_in;

  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             beat_acc, last_beat;
  logic [1:0]       beat_resp;
  logic [31:0]      resv_nxt;
  logic             space_ok;

  // Tag FIFO status
  assign tag_cnt   = tag_wp - tag_rp;
  assign tag_full  = (tag_cnt == TAG_PW'(TAG_DEPTH));
  assign tag_empty = (tag_wp == tag_rp);
  assign tag_head  = tag_mem[tag_rp[TAG_AW-1:0]];

  assign beat_acc  = dfi_rddata_valid && !tag_empty;
  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
  assign tag_push  = rd_gnt && !tag_full;
  assign tag_pop   = beat_acc && last_beat;

  // Data FIFO status; the output register is an extra slot outside d_cnt
  assign d_cnt    = d_wp - d_rp;
  assign d_full   = (d_cnt == FIFO_PW'(FIFO_DEPTH));
  assign d_empty  = (d_wp == d_rp);
  assign out_load = !d_empty && (!rvalid || rready);
  assign d_push   = beat_acc && (!d_full || out_load);

`ifdef SAL_RD_PARITY_CHK_EN
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    beat_resp = 2'b00;
    if ((^dfi_rddata) != dfi_rddata_par) beat_resp = 2'b10;
  end
`else
  logic unused_par;
  assign unused_par = dfi_rddata_par;
  assign beat_resp  = 2'b00;
`endif

  assign beat_in = '{data: dfi_rddata, id: tag_head.id,
                     last: tag_head.last && last_beat, resp: beat_resp};

  // Look-ahead credit: state as it will be after this edge
  assign beat_cnt_nxt = !beat_acc ? beat_cnt : (last_beat ? '0 : beat_cnt + CNT_W'(1));
  assign tag_cnt_nxt  = tag_cnt + TAG_PW'(tag_push) - TAG_PW'(tag_pop);
  assign d_cnt_nxt    = d_cnt + FIFO_PW'(d_push) - FIFO_PW'(out_load);
  assign resv_nxt     = 32'(tag_cnt_nxt) * 32'(BEATS) - 32'(beat_cnt_nxt);
  assign space_ok     = (32'(d_cnt_nxt) + resv_nxt + 32'(BEATS)) <= 32'(FIFO_DEPTH);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wp    <= '0;
      tag_rp    <= '0;
      d_wp      <= '0;
      d_rp      <= '0;
      beat_cnt  <= '0;
      err_unexp <= 1'b0;
      rd_ready  <= 1'b0;
      rvalid    <= 1'b0;
      r_q       <= '0;
    end else begin
      if (tag_push) tag_wp <= tag_wp + TAG_PW'(1);
      if (tag_pop)  tag_rp <= tag_rp + TAG_PW'(1);
      if (d_push)   d_wp   <= d_wp + FIFO_PW'(1);
      if (out_load) d_rp   <= d_rp + FIFO_PW'(1);
      beat_cnt <= beat_cnt_nxt;
      if ((rd_gnt && tag_full) || (dfi_rddata_valid && tag_empty)) err_unexp <= 1'b1;
      rd_ready <= space_ok && (tag_cnt_nxt != TAG_PW'(TAG_DEPTH));
      if (out_load) begin
        rvalid <= 1'b1;
        r_q    <= dmem[d_rp[FIFO_AW-1:0]];
      end else if (rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // NOTE: storage arrays are not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wp[TAG_AW-1:0]] <= '{id: rd_id, last: rd_last};
    if (d_push)   dmem[d_wp[FIFO_AW-1:0]]     <= beat_in;
  end

  assign rid   = r_q.id;
  assign rdata = r_q.data;
  assign rresp = r_q.resp;
  assign rlast = r_q.last;

endmodule

// File: tb/tb_sal_rd_ctrl.sv
// Scoreboard bench for sal_rd_ctrl: a small tag/beat model predicts every R beat.
module tb_sal_rd_ctrl;

  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int BEATS  = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            last;
  } mtag_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              last;
    logic [1:0]        resp;
  } exp_t;

  logic              clk, rst_n;
  logic              rd_gnt, rd_last, rd_ready;
  logic [ID_W-1:0]   rd_id;
  logic              dfi_rddata_valid, dfi_rddata_par;
  logic [DATA_W-1:0] dfi_rddata;
  logic              rvalid, rready, rlast, err_unexp;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  int    vectors = 0;
  int    miscompares = 0;
  mtag_t tq[$];
  exp_t  sb[$];
  int    m_beat = 0;

  sal_rd_ctrl #(.DATA_W(DATA_W), .ID_W(ID_W), .BEATS(BEATS), .TAG_DEPTH(4), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_gnt(rd_gnt), .rd_id(rd_id), .rd_last(rd_last), .rd_ready(rd_ready),
    .dfi_rddata_valid(dfi_rddata_valid), .dfi_rddata(dfi_rddata), .dfi_rddata_par(dfi_rddata_par),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .err_unexp(err_unexp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge sample them, return 1ns after it.
  task automatic step(input bit g, input logic [ID_W-1:0] id, input bit last,
                      input bit v, input logic [DATA_W-1:0] d, input bit par);
    logic [1:0] resp;
    rd_gnt = g; rd_id = id; rd_last = last;
    dfi_rddata_valid = v; dfi_rddata = d; dfi_rddata_par = par;
    if (v && tq.size() > 0) begin
`ifdef SAL_RD_PARITY_CHK_EN
      resp = ((^d) != par) ? 2'b10 : 2'b00;
`else
      resp = 2'b00;
`endif
      sb.push_back('{id: tq[0].id, data: d, last: tq[0].last && (m_beat == BEATS - 1), resp: resp});
      if (m_beat == BEATS - 1) begin
        m_beat = 0;
        void'(tq.pop_front());
      end else begin
        m_beat++;
      end
    end
    if (g) tq.push_back('{id: id, last: last});
    @(posedge clk);
    #1;
    rd_gnt = 1'b0; dfi_rddata_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (sb.size() > 0 && c < budget) begin
      idle(1);
      c++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  // Scoreboard pop: the beat on the bus at negedge is consumed at the next edge.
  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      if (sb.size() == 0) begin
        check("spurious_r", {rid, rdata, rlast, rresp}, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("r_beat", {rid, rdata, rlast, rresp}, {e.id, e.data, e.last, e.resp});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcnt;
    int bcnt;
    rst_n = 1'b0; rready = 1'b0;
    rd_gnt = 1'b0; rd_id = '0; rd_last = 1'b0;
    dfi_rddata_valid = 1'b0; dfi_rddata = '0; dfi_rddata_par = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_err", err_unexp, 0);
    check("rst_rd_ready", rd_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rd_ready_rise", rd_ready, 1);

    // Single RD with latency checks
    rready = 1'b1;
    step(1'b1, 4'd3, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 64'hA, 1'b0);
    check("lat_pre", rvalid, 0);
    step(1'b0, '0, 1'b0, 1'b1, 64'hB, 1'b1);
    check("lat_a_valid", rvalid, 1);
    check("lat_a_data", {rid, rdata, rlast}, {4'd3, 64'hA, 1'b0});
    idle(1);
    check("lat_b_data", {rid, rdata, rlast}, {4'd3, 64'hB, 1'b1});
    wait_drain(20);

    // Four RDs forming two bursts
    for (int i = 0; i < 4; i++) begin
      check("burst_ready", rd_ready, 1);
      step(1'b1, (i < 2) ? 4'd1 : 4'd2, i[0], 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      logic [DATA_W-1:0] d;
      d = 64'h1000 + 64'(i);
      step(1'b0, '0, 1'b0, 1'b1, d, ^d);
    end
    wait_drain(30);

    // Backpressure: eight RDs with rready low
    rready = 1'b0;
    gcnt = 0;
    bcnt = 0;
    for (int c = 0; c < 80 && (gcnt < 8 || tq.size() > 0); c++) begin
      bit g, v;
      logic [DATA_W-1:0] d;
      g = rd_ready && (gcnt < 8);
      v = (tq.size() > 0);
      d = 64'h100 + 64'(bcnt);
      step(g, 4'(gcnt), 1'b1, v, d, ^d);
      if (g) gcnt++;
      if (v) bcnt++;
    end
    idle(2);
    check("bp_grants", gcnt, 8);
    check("bp_beats", bcnt, 16);
    check("bp_ready_low", rd_ready, 0);
    check("bp_held", sb.size(), 16);
    check("bp_hold_data", {rvalid, rid, rdata}, {1'b1, 4'd0, 64'h100});
    rready = 1'b1;
    wait_drain(60);
    idle(2);
    check("bp_ready_back", rd_ready, 1);

    // Parity on read data
    step(1'b1, 4'd5, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 64'h1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 64'h3, 1'b0);
    wait_drain(20);

    // Beat with nothing outstanding
    check("unexp_before", err_unexp, 0);
    step(1'b0, '0, 1'b0, 1'b1, 64'hDEAD, 1'b0);
    idle(3);
    check("unexp_set", err_unexp, 1);
    check("unexp_no_r", rvalid, 0);
    idle(5);
    check("unexp_sticky", err_unexp, 1);

    // Reset in the middle of a 2-beat RD
    step(1'b1, 4'd7, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 64'h55, 1'b0);
    #2;
    rst_n = 1'b0;
    tq.delete();
    sb.delete();
    m_beat = 0;
    #1;
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_err", err_unexp, 0);
    check("mid_rst_ready", rd_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", rd_ready, 1);
    idle(4);
    check("post_rst_rvalid", rvalid, 0);

    // Clean operation after reset
    step(1'b1, 4'd9, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 64'h77, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 64'h88, 1'b0);
    wait_drain(20);
    check("post_rst_err", err_unexp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
